// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the convolution layer sequencer.
// Optional build macro used by conv_layer_ctrl: CONV_CTRL_PERF_EN.
package conv_ctrl_pkg;

   // Sequencer states, one window per START..EMIT loop
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WAIT  = 3'd4,
      ST_EMIT  = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // Taps per window
   function automatic int unsigned taps_of(input int unsigned k);
      return k * k;
   endfunction

   // Number of valid window positions along one image axis
   function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
      return img - k + 1;
   endfunction

   // Counter/address width for n distinct values, never narrower than 1 bit
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// Window tap walker: steps kr/kc row-major through a KxK window and keeps the
// feature RAM address and weight tap index registered alongside.
module conv_win_addr_gen
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned IMG_W = 28,
   parameter int unsigned IMG_H = 28,
   parameter int unsigned K     = 5
)(
   input  logic                                      clk,
   input  logic                                      n_reset,
   input  logic                                      clear,
   input  logic                                      step,
   input  logic [width_of(out_dim(IMG_H, K))-1:0]    row,
   input  logic [width_of(out_dim(IMG_W, K))-1:0]    col,
   output logic [width_of(IMG_W*IMG_H)-1:0]          fmap_addr,
   output logic [width_of(taps_of(K))-1:0]           wt_tap,
   output logic                                      last_tap_c
);

   localparam int unsigned ADDR_W = width_of(IMG_W * IMG_H);
   localparam int unsigned TAP_W  = width_of(taps_of(K));
   localparam int unsigned KC_W   = width_of(K);

   logic [KC_W-1:0] kr;
   logic [KC_W-1:0] kc;

   // Final tap of the window is reached when both kernel coordinates are at K-1
   assign last_tap_c = (kr == KC_W'(K - 1)) && (kc == KC_W'(K - 1));

   // Tap counters and incremental address: +1 along a kernel row, jump to next image row at kc wrap
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         kr        <= '0;
         kc        <= '0;
         wt_tap    <= '0;
         fmap_addr <= '0;
      end else if (clear) begin
         kr        <= '0;
         kc        <= '0;
         wt_tap    <= '0;
         fmap_addr <= ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
      end else if (step) begin
         wt_tap <= wt_tap + TAP_W'(1);
         if (kc == KC_W'(K - 1)) begin
            kc        <= '0;
            kr        <= kr + KC_W'(1);
            fmap_addr <= fmap_addr + ADDR_W'(IMG_W - K + 1);
         end else begin
            kc        <= kc + KC_W'(1);
            fmap_addr <= fmap_addr + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/conv_layer_ctrl.sv
// Convolution layer sequencer: per window pulses the PEs, streams K*K taps,
// waits for all PE flags and hands the result downstream via valid/ready.
// Optional build macro: CONV_CTRL_PERF_EN adds stall_cycles / wait_cycles counters.
module conv_layer_ctrl
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28,
   parameter int unsigned K      = 5,
   parameter int unsigned NUM_CH = 3
)(
   input  logic                                      clk,
   input  logic                                      n_reset,
   input  logic                                      go,
   output logic                                      busy,
   output logic                                      done,
   output logic [width_of(IMG_W*IMG_H)-1:0]          fmap_addr,
   output logic                                      fmap_rd_en,
   output logic [width_of(taps_of(K))-1:0]           wt_tap,
   output logic                                      pe_start,
   output logic                                      pe_ready_in,
   input  logic [NUM_CH-1:0]                         pe_flag,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [width_of(out_dim(IMG_H, K))-1:0]    out_row,
   output logic [width_of(out_dim(IMG_W, K))-1:0]    out_col,
   output logic                                      err
`ifdef CONV_CTRL_PERF_EN
   ,
   output logic [31:0]                               stall_cycles,
   output logic [31:0]                               wait_cycles
`endif
);

   localparam int unsigned OUT_W = out_dim(IMG_W, K);
   localparam int unsigned OUT_H = out_dim(IMG_H, K);
   localparam int unsigned ROW_W = width_of(OUT_H);
   localparam int unsigned COL_W = width_of(OUT_W);

   state_t             state_q;
   state_t             state_d;
   logic [ROW_W-1:0]   row_d;
   logic [COL_W-1:0]   col_d;
   logic               err_d;
   logic               gen_clear_c;
   logic               gen_step_c;
   logic               last_tap_c;
   logic               last_win_c;

   assign last_win_c = (out_row == ROW_W'(OUT_H - 1)) && (out_col == COL_W'(OUT_W - 1));

   // Window tap address generator
   conv_win_addr_gen #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .K     (K)
   ) u_addr_gen (
      .clk        (clk),
      .n_reset    (n_reset),
      .clear      (gen_clear_c),
      .step       (gen_step_c),
      .row        (row_d),
      .col        (col_d),
      .fmap_addr  (fmap_addr),
      .wt_tap     (wt_tap),
      .last_tap_c (last_tap_c)
   );

   // Next state, window position, error flag and tap walker controls
   always_comb begin
      state_d     = state_q;
      row_d       = out_row;
      col_d       = out_col;
      err_d       = err;
      gen_clear_c = 1'b0;
      gen_step_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               state_d     = ST_START;
               row_d       = '0;
               col_d       = '0;
               err_d       = 1'b0;
               gen_clear_c = 1'b1;
            end
         end
         ST_START: begin
            gen_clear_c = 1'b1;
            state_d     = ST_FEED;
         end
         ST_FEED: begin
            if (last_tap_c) state_d = ST_DRAIN;
            else            gen_step_c = 1'b1;
         end
         ST_DRAIN: state_d = ST_WAIT;
         ST_WAIT: begin
            if (&pe_flag)      state_d = ST_EMIT;
            else if (|pe_flag) err_d   = 1'b1;
         end
         ST_EMIT: begin
            if (out_ready) begin
               if (last_win_c) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_START;
                  if (out_col == COL_W'(OUT_W - 1)) begin
                     col_d = '0;
                     row_d = out_row + ROW_W'(1);
                  end else begin
                     col_d = out_col + COL_W'(1);
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and registered outputs decoded from the next state
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q     <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         fmap_rd_en  <= 1'b0;
         pe_start    <= 1'b0;
         pe_ready_in <= 1'b0;
         out_valid   <= 1'b0;
         out_row     <= '0;
         out_col     <= '0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy        <= (state_d != ST_IDLE);
         done        <= (state_d == ST_DONE);
         fmap_rd_en  <= (state_d == ST_FEED);
         pe_start    <= (state_d == ST_START);
         pe_ready_in <= fmap_rd_en;
         out_valid   <= (state_d == ST_EMIT);
         out_row     <= row_d;
         out_col     <= col_d;
         err         <= err_d;
      end
   end

`ifdef CONV_CTRL_PERF_EN
   // Saturating stall / wait counters, restarted at each accepted go
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         stall_cycles <= '0;
         wait_cycles  <= '0;
      end else if (state_q == ST_IDLE && go) begin
         stall_cycles <= '0;
         wait_cycles  <= '0;
      end else begin
         if (out_valid && !out_ready && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
         if (state_q == ST_WAIT && wait_cycles != 32'hFFFF_FFFF)
            wait_cycles <= wait_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Scoreboard bench for conv_layer_ctrl on a 6x6 map with a 3x3 kernel.
// Optional build macro: CONV_CTRL_PERF_EN enables the perf counter checks.
module tb_conv_layer_ctrl;

   typedef struct {
      int addr;
      int tap;
   } feed_t;

   typedef struct {
      int row;
      int col;
   } win_t;

   logic       clk;
   logic       n_reset;
   logic       go;
   logic       busy;
   logic       done;
   logic [5:0] fmap_addr;
   logic       fmap_rd_en;
   logic [3:0] wt_tap;
   logic       pe_start;
   logic       pe_ready_in;
   logic [2:0] pe_flag;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_row;
   logic [1:0] out_col;
   logic       err;
`ifdef CONV_CTRL_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] wait_cycles;
`endif

   conv_layer_ctrl #(
      .IMG_W  (6),
      .IMG_H  (6),
      .K      (3),
      .NUM_CH (3)
   ) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .go          (go),
      .busy        (busy),
      .done        (done),
      .fmap_addr   (fmap_addr),
      .fmap_rd_en  (fmap_rd_en),
      .wt_tap      (wt_tap),
      .pe_start    (pe_start),
      .pe_ready_in (pe_ready_in),
      .pe_flag     (pe_flag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_col     (out_col),
      .err         (err)
`ifdef CONV_CTRL_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .wait_cycles  (wait_cycles)
`endif
   );

   int    n_chk = 0;
   int    n_pass = 0;
   feed_t feed_q[$];
   win_t  win_q[$];
   int    rdy_cnt = 0;
   int    start_cnt = 0;
   int    acc_cnt = 0;
   bit    err_mode = 1'b0;
   int    stall_row = -1;
   int    stall_col = -1;
   int    stall_left = 0;
   int    pe_cnt = 0;
   int    pe_dly = -1;
   int    w0_addr[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
   int    w1_addr[9] = '{1, 2, 3, 7, 8, 9, 13, 14, 15};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endfunction

   // PE model: all flags 2 cycles after the 9th ready_in; err mode raises flag[0] one cycle early
   always @(negedge clk) begin
      if (!n_reset) begin
         pe_cnt  = 0;
         pe_dly  = -1;
         pe_flag = 3'b000;
      end else begin
         if (pe_start) begin
            pe_flag = 3'b000;
            pe_cnt  = 0;
            pe_dly  = -1;
         end
         if (pe_ready_in) begin
            pe_cnt++;
            if (pe_cnt == 9) pe_dly = 0;
         end else if (pe_dly >= 0) begin
            pe_dly++;
            if (err_mode && pe_dly == 1) pe_flag[0] = 1'b1;
            if (pe_dly == 2) begin
               pe_flag = 3'b111;
               pe_dly  = -1;
            end
         end
      end
   end

   // Downstream: ready except for the configured window, held off for stall_left cycles
   always @(posedge clk) begin
      #2;
      if (out_valid && stall_left > 0 && int'(out_row) == stall_row && int'(out_col) == stall_col) begin
         out_ready = 1'b0;
         stall_left--;
      end else begin
         out_ready = 1'b1;
      end
   end

   // Monitor: pops expected taps and windows whenever the DUT presents them
   always @(negedge clk) begin
      if (n_reset) begin
         if (fmap_rd_en) begin
            if (feed_q.size() == 0) begin
               chk("feed_unexpected", 1, 0);
            end else begin
               feed_t f;
               f = feed_q.pop_front();
               chk("fmap_addr", int'(fmap_addr), f.addr);
               chk("wt_tap", int'(wt_tap), f.tap);
            end
         end
         if (pe_ready_in) rdy_cnt++;
         if (pe_start) start_cnt++;
         if (out_valid) begin
            if (win_q.size() == 0) begin
               chk("window_unexpected", 1, 0);
            end else begin
               chk("out_row", int'(out_row), win_q[0].row);
               chk("out_col", int'(out_col), win_q[0].col);
               if (out_ready) begin
                  void'(win_q.pop_front());
                  acc_cnt++;
               end
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_fmap_addr"}, int'(fmap_addr), 0);
      chk({tag, "_fmap_rd_en"}, int'(fmap_rd_en), 0);
      chk({tag, "_wt_tap"}, int'(wt_tap), 0);
      chk({tag, "_pe_start"}, int'(pe_start), 0);
      chk({tag, "_pe_ready_in"}, int'(pe_ready_in), 0);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_row"}, int'(out_row), 0);
      chk({tag, "_out_col"}, int'(out_col), 0);
      chk({tag, "_err"}, int'(err), 0);
`ifdef CONV_CTRL_PERF_EN
      chk({tag, "_stall_cycles"}, int'(stall_cycles), 0);
      chk({tag, "_wait_cycles"}, int'(wait_cycles), 0);
`endif
   endtask

   // Push expected windows/taps for a full pass, then pulse go and confirm it was taken
   task automatic start_pass(input bit err_m, input int srow, input int scol);
      err_mode   = err_m;
      stall_row  = srow;
      stall_col  = scol;
      stall_left = (srow >= 0) ? 5 : 0;
      rdy_cnt    = 0;
      start_cnt  = 0;
      acc_cnt    = 0;
      for (int w = 0; w < 16; w++) begin
         win_t wn;
         wn.row = w / 4;
         wn.col = w % 4;
         win_q.push_back(wn);
         for (int t = 0; t < 9; t++) begin
            feed_t f;
            if (w == 0)      f.addr = w0_addr[t];
            else if (w == 1) f.addr = w1_addr[t];
            else             f.addr = (wn.row + t / 3) * 6 + wn.col + t % 3;
            f.tap = t;
            feed_q.push_back(f);
         end
      end
      @(posedge clk);
      #2 go = 1'b1;
      @(posedge clk);
      #2 go = 1'b0;
      chk("go_busy", int'(busy), 1);
      chk("go_pe_start", int'(pe_start), 1);
      chk("go_err_clear", int'(err), 0);
   endtask

   // Wait (bounded) for done, check its cycle index and the per-pass totals
   task automatic wait_done(input int exp_n, input bit go_in_busy, input int exp_err, input int exp_stall);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (n < 400 && !seen) begin
         @(negedge clk);
         go = (go_in_busy && n == 50) ? 1'b1 : 1'b0;
         if (done) begin
            seen = 1'b1;
            chk("done_cycle", n, exp_n);
            chk("done_busy", int'(busy), 1);
`ifdef CONV_CTRL_PERF_EN
            chk("stall_cycles", int'(stall_cycles), exp_stall);
            chk("wait_cycles", int'(wait_cycles), 32);
`endif
         end
         n++;
      end
      go = 1'b0;
      if (!seen) chk("done_timeout", 0, 1);
      chk("windows_accepted", acc_cnt, 16);
      chk("pe_start_count", start_cnt, 16);
      chk("ready_in_count", rdy_cnt, 144);
      chk("windows_left", win_q.size(), 0);
      chk("taps_left", feed_q.size(), 0);
      @(negedge clk);
      chk("done_single", int'(done), 0);
      chk("busy_after", int'(busy), 0);
      chk("err_after", int'(err), exp_err);
      if (exp_stall < 0) chk("never", 0, 1);
   endtask

   initial begin
      n_reset   = 1'b0;
      go        = 1'b0;
      out_ready = 1'b1;
      #12;
      check_zero("reset");
      @(posedge clk);
      #2 n_reset = 1'b1;

      // Stall window (2,1) for 5 cycles and pulse go while busy
      start_pass(1'b0, 2, 1);
      wait_done(229, 1'b1, 0, 5);

      // PE flags disagree for one cycle per window
      start_pass(1'b1, -1, -1);
      wait_done(224, 1'b0, 1, 0);

      // Reset during FEED of window (1,2), third tap
      start_pass(1'b0, -1, -1);
      repeat (88) @(negedge clk);
      chk("abort_rd_en", int'(fmap_rd_en), 1);
      chk("abort_tap", int'(wt_tap), 2);
      chk("abort_addr", int'(fmap_addr), 10);
      #2 n_reset = 1'b0;
      #1 check_zero("midpass_reset");
      feed_q.delete();
      win_q.delete();
      repeat (3) @(posedge clk);
      #2 n_reset = 1'b1;

      // Fresh pass after the abort starts at window (0,0)
      start_pass(1'b0, -1, -1);
      wait_done(224, 1'b0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/conv_layer_ctrl.md
Name: conv_layer_ctrl

Overview:
- Sequencer for the 3-channel convolution layer: slides a KxK window over an IMG_H x IMG_W input feature map stored in single-port feature RAM.
- Per window: issues one PE start pulse, streams K*K taps (feature address plus tap index for weight ROM) with an aligned ready_in, waits for all PE completion flags, then hands the window result downstream via valid/ready.
- Sits between the feature/weight memories, the 3-PE conv layer, and the pooling stage.

Parameters:
- IMG_W, 28, input map width in pixels.
- IMG_H, 28, input map height in pixels.
- K, 5, kernel side; taps per window = K*K.
- NUM_CH, 3, number of parallel conv PEs (output channels).

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- go  in  1  start a full-map pass; sampled only in IDLE.
- busy  out  1  high from the cycle after go is accepted until DONE exits.
- done  out  1  one-cycle pulse after the last window is accepted downstream.
- fmap_addr  out  $clog2(IMG_W*IMG_H)  feature RAM read address.
- fmap_rd_en  out  1  feature RAM read enable; RAM data valid one cycle later.
- wt_tap  out  $clog2(K*K)  tap index to weight ROM, aligned with fmap_addr.
- pe_start  out  1  one-cycle start pulse to all PEs.
- pe_ready_in  out  1  tap-valid strobe to PEs, equal to fmap_rd_en delayed 1 cycle.
- pe_flag  in  NUM_CH  per-PE completion flags.
- out_valid  out  1  window result available from the PEs.
- out_ready  in  1  downstream accepts the result.
- out_row  out  $clog2(IMG_H-K+1)  output row of the current window.
- out_col  out  $clog2(IMG_W-K+1)  output column of the current window.
- err  out  1  sticky: PE flags disagreed; cleared only by reset or go.

Behaviour:
- Reset (asynchronous, n_reset low): state IDLE; every output 0, all counters 0, err 0. Reset mid-pass abandons the pass with no done pulse.
- States: IDLE, START, FEED, DRAIN, WAIT, EMIT, DONE.
- IDLE: go=1 -> START. Clear row/col, tap, err. go is ignored in every other state.
- START: pe_start=1 for exactly one cycle -> FEED.
- FEED: K*K consecutive cycles with fmap_rd_en=1.
  - tap t = kr*K+kc runs 0..K*K-1, row-major.
  - fmap_addr = (row+kr)*IMG_W + (col+kc); wt_tap = t.
  - After tap K*K-1 -> DRAIN.
- DRAIN: one cycle, no read; the last pe_ready_in is asserted here -> WAIT.
- WAIT:
  - All pe_flag bits high -> EMIT.
  - Some but not all bits high in any cycle: set err; keep waiting for all-high. No timeout.
- EMIT: out_valid=1 with out_row/out_col stable until out_ready=1.
  - On acceptance, col increments. If col reaches IMG_W-K: col wraps to 0 and row increments.
  - If the accepted window was the last (row=IMG_H-K, col=IMG_W-K) -> DONE; otherwise -> START.
  - out_ready may be high on the first EMIT cycle (zero-stall acceptance).
- DONE: done=1 for one cycle, busy drops -> IDLE.
- Throughput: K*K+3 cycles per window plus WAIT and EMIT stall cycles.
- Address arithmetic is unsigned and never exceeds IMG_W*IMG_H-1; no wrap logic is needed inside a window.

Optional Feature:
- Macro CONV_CTRL_PERF_EN.
- Defined: adds two 32-bit outputs, reset to 0 and cleared on go:
  - stall_cycles: counts cycles with out_valid & !out_ready.
  - wait_cycles: counts cycles spent in WAIT.
  - Both counters saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- conv_ctrl_pkg holds:
  - state enum (IDLE, START, FEED, DRAIN, WAIT, EMIT, DONE);
  - localparam-style functions for TAPS=K*K, OUT_W=IMG_W-K+1, OUT_H=IMG_H-K+1, and address widths.
- One sub-module, conv_win_addr_gen: tap counter plus kr/kc, computes fmap_addr and wt_tap from row/col; controlled by clear/step and reports last_tap.

Test Plan (IMG_W=IMG_H=6, K=3, NUM_CH=3):
- go pulse, PE model flags 2 cycles after last ready_in, out_ready=1 -> first window fmap_addr 0,1,2,6,7,8,12,13,14; wt_tap 0..8; 9 pe_ready_in strobes; 16 windows; done after the (3,3) acceptance; busy low afterwards.
- Second window -> addresses 1,2,3,7,8,9,13,14,15. Window (1,0) starts at address 6.
- out_ready held low 5 cycles in window (2,1) -> out_valid/out_row=2/out_col=1 stable; with CONV_CTRL_PERF_EN, stall_cycles=5 at done.
- PE model raises flag[0] one cycle before flags[2:1] -> err=1 stays set; pass still completes 16 windows.
- n_reset low during FEED of window (1,2) -> all outputs 0 immediately; new go restarts at window (0,0) with err=0.
- go asserted while busy -> ignored; window count and done timing unchanged.
